// File: rtl/service_arbiter.sv
// Mode controller for the alarm clock: debounces buttons, picks the service that owns
// buttons and display, and sequences alarm ring -> mini-game -> dismissal.
module service_arbiter #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 20
) (
  input  logic       clk_osc,
  input  logic       rst_n,
  input  logic [4:0] push_raw,
  input  logic [3:0] svc_sw,
  input  logic       alarm_match,
  input  logic       game_win,
  input  logic       game_fail,
  output logic [4:0] push_time,
  output logic [4:0] push_alarm,
  output logic [4:0] push_sw,
  output logic [4:0] push_game,
  output logic       game_start,
  output logic [2:0] disp_sel,
  output logic       ringing
);

  typedef enum logic [2:0] {
    CLOCK  = 3'd0,
    TSET   = 3'd1,
    ASET   = 3'd2,
    SWATCH = 3'd3,
    RING   = 3'd4,
    GAME   = 3'd5
  } state_t;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [4:0]       push_p0, push_p1;
  logic [3:0]       sw_p0, sw_p1;
  logic             match_p0, match_prev;
  logic [DEB_W-1:0] deb_cnt [5];
  logic [4:0]       deb_lvl;
  logic [4:0]       pulse_p2;
  logic             ring_rise;

  state_t     state, next;
  logic [4:0] time_d, alarm_d, sw_d, game_d;
  logic       start_d, ring_d;

  // Input synchronisers; the alarm edge flops reset high so a match already
  // present when reset releases is not seen as a rising edge.
  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      push_p0    <= '0;
      push_p1    <= '0;
      sw_p0      <= '0;
      sw_p1      <= '0;
      match_p0   <= 1'b1;
      match_prev <= 1'b1;
    end else begin
      push_p0    <= push_raw;
      push_p1    <= push_p0;
      sw_p0      <= svc_sw;
      sw_p1      <= sw_p0;
      match_p0   <= alarm_match;
      match_prev <= match_p0;
    end
  end

  // Debounce: level flips after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
      deb_lvl  <= '0;
      pulse_p2 <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        pulse_p2[i] <= 1'b0;
        if (push_p1[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]  <= '0;
          deb_lvl[i]  <= push_p1[i];
          pulse_p2[i] <= push_p1[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ring_rise = match_p0 & ~match_prev & sw_p1[0];

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) state <= CLOCK;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      CLOCK, TSET, ASET, SWATCH: begin
        if (ring_rise)      next = RING;
        else if (sw_p1[3])  next = TSET;
        else if (sw_p1[2])  next = ASET;
        else if (sw_p1[1])  next = SWATCH;
        else                next = CLOCK;
      end
      RING: begin
        if (!sw_p1[0])        next = CLOCK;
        else if (pulse_p2[4]) next = GAME;
      end
      GAME: begin
        if (!sw_p1[0])      next = CLOCK;
        else if (game_win)  next = CLOCK;
        else if (game_fail) next = RING;
      end
      default: next = CLOCK;
    endcase
  end

  // Pulses follow the current state, so a press coinciding with a change lands on the old bus
  always_comb begin
    time_d  = '0;
    alarm_d = '0;
    sw_d    = '0;
    game_d  = '0;
    case (state)
      TSET:    time_d  = pulse_p2;
      ASET:    alarm_d = pulse_p2;
      SWATCH:  sw_d    = pulse_p2;
      GAME:    game_d  = pulse_p2;
      default: ;
    endcase
    start_d = (state == RING) && (next == GAME);
    ring_d  = (next == RING) || (next == GAME);
  end

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      push_time  <= '0;
      push_alarm <= '0;
      push_sw    <= '0;
      push_game  <= '0;
      game_start <= 1'b0;
      disp_sel   <= 3'd0;
      ringing    <= 1'b0;
    end else begin
      push_time  <= time_d;
      push_alarm <= alarm_d;
      push_sw    <= sw_d;
      push_game  <= game_d;
      game_start <= start_d;
      disp_sel   <= next;
      ringing    <= ring_d;
    end
  end

endmodule

// File: tb/tb_service_arbiter.sv
// Directed bench for service_arbiter: reset, debounce, priority, ring and game sequencing.
module tb_service_arbiter;

  logic       clk_osc = 1'b0;
  logic       rst_n;
  logic [4:0] push_raw;
  logic [3:0] svc_sw;
  logic       alarm_match, game_win, game_fail;
  logic [4:0] push_time, push_alarm, push_sw, push_game;
  logic       game_start, ringing;
  logic [2:0] disp_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no, first_time;
  int hi_time, hi_alarm, hi_sw, hi_game, hi_start, hi_ring;

  service_arbiter #(.DEB_CYCLES(4), .DEB_W(20)) dut (
    .clk_osc(clk_osc), .rst_n(rst_n), .push_raw(push_raw), .svc_sw(svc_sw),
    .alarm_match(alarm_match), .game_win(game_win), .game_fail(game_fail),
    .push_time(push_time), .push_alarm(push_alarm), .push_sw(push_sw),
    .push_game(push_game), .game_start(game_start), .disp_sel(disp_sel),
    .ringing(ringing)
  );

  always #5 clk_osc = ~clk_osc;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    tick_no = 0; first_time = -1;
    hi_time = 0; hi_alarm = 0; hi_sw = 0; hi_game = 0; hi_start = 0; hi_ring = 0;
  endtask

  task automatic tick();
    @(posedge clk_osc);
    #1;
    tick_no++;
    if (push_time[0] && first_time < 0) first_time = tick_no;
    hi_time  += $countones(push_time);
    hi_alarm += $countones(push_alarm);
    hi_sw    += $countones(push_sw);
    hi_game  += $countones(push_game);
    hi_start += int'(game_start);
    hi_ring  += int'(ringing);
  endtask

  task automatic press(input int idx);
    push_raw[idx] = 1'b1;
    repeat (12) tick();
    push_raw = '0;
    repeat (8) tick();
  endtask

  task automatic ring_up();
    alarm_match = 1'b0;
    repeat (3) tick();
    alarm_match = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    push_raw = '0; svc_sw = 4'b0001; alarm_match = 1'b1;
    game_win = 1'b0; game_fail = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    clr();
    repeat (3) tick();
    check("rst_disp", disp_sel, 0);
    check("rst_ring", ringing, 0);
    check("rst_push_time", push_time, 0);
    check("rst_start", game_start, 0);
    rst_n = 1'b1;
    clr();
    repeat (100) tick();
    check("post_rst_no_ring", hi_ring, 0);
    check("post_rst_disp", disp_sel, 0);

    // Debounce into time set
    alarm_match = 1'b0; svc_sw = 4'b1000;
    repeat (4) tick();
    check("tset_disp", disp_sel, 1);
    clr();
    push_raw[0] = 1'b1;
    repeat (20) tick();
    push_raw = '0;
    repeat (10) tick();
    check("deb_pulse_count", hi_time, 1);
    check("deb_latency", first_time, 7);
    check("deb_other_buses", hi_alarm + hi_sw + hi_game, 0);
    clr();
    push_raw[0] = 1'b1;
    repeat (2) tick();
    push_raw = '0;
    repeat (15) tick();
    check("glitch_no_pulse", hi_time, 0);

    // Switch priority
    svc_sw = 4'b1110; repeat (4) tick();
    check("prio_tset", disp_sel, 1);
    svc_sw = 4'b0110; repeat (4) tick();
    check("prio_aset", disp_sel, 2);
    svc_sw = 4'b0010; repeat (4) tick();
    check("prio_swatch", disp_sel, 3);
    clr();
    press(4);
    check("sw_center_bus", push_sw, 0);
    check("sw_center_count", hi_sw, 1);
    check("sw_center_others", hi_time + hi_alarm + hi_game, 0);

    // Ring preemption
    svc_sw = 4'b1001; repeat (4) tick();
    check("pre_ring_tset", disp_sel, 1);
    alarm_match = 1'b1; repeat (3) tick();
    check("ring_disp", disp_sel, 4);
    check("ring_led", ringing, 1);
    clr();
    press(0);
    check("ring_up_dropped", hi_time + hi_alarm + hi_sw + hi_game + hi_start, 0);
    svc_sw = 4'b0001; repeat (4) tick();
    check("ring_ignores_sw", disp_sel, 4);

    // Game flow
    clr();
    press(4);
    check("game_start_once", hi_start, 1);
    check("center_not_routed", hi_game, 0);
    check("game_disp", disp_sel, 5);
    check("game_ring", ringing, 1);
    game_fail = 1'b1; tick(); game_fail = 1'b0;
    check("fail_disp", disp_sel, 4);
    check("fail_ring", ringing, 1);
    press(4);
    check("regame_disp", disp_sel, 5);
    clr();
    press(0);
    check("game_up_routed", hi_game, 1);
    game_win = 1'b1; tick(); game_win = 1'b0;
    check("win_disp", disp_sel, 0);
    check("win_ring", ringing, 0);
    clr();
    repeat (50) tick();
    check("win_no_rering", hi_ring, 0);
    check("win_stays_clock", disp_sel, 0);

    // Cancel from GAME
    ring_up();
    check("cancel_ring_disp", disp_sel, 4);
    press(4);
    check("cancel_game_disp", disp_sel, 5);
    svc_sw = 4'b0000; repeat (3) tick();
    check("cancel_disp", disp_sel, 0);
    check("cancel_ring", ringing, 0);

    // Simultaneous win and fail
    svc_sw = 4'b0001; repeat (4) tick();
    ring_up();
    press(4);
    check("sim_game_disp", disp_sel, 5);
    game_win = 1'b1; game_fail = 1'b1; tick();
    game_win = 1'b0; game_fail = 1'b0;
    check("sim_disp", disp_sel, 0);
    check("sim_ring", ringing, 0);
    repeat (3) tick();
    check("sim_disp_hold", disp_sel, 0);

    // Reset while ringing
    ring_up();
    check("mid_ring_on", ringing, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_ring", ringing, 0);
    check("mid_rst_disp", disp_sel, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    clr();
    repeat (30) tick();
    check("mid_rst_no_rering", hi_ring, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
